adder_pipe: RTL and testbench
=============================

ADDER_PIPE -- requirements
Module: adder_pipe

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits; SHALL be at least 2.
REQ-002 Parameter STAGES, default 4: pipeline depth; SHALL divide WIDTH exactly; each stage handles a slice of SLICE = WIDTH/STAGES bits.
REQ-003 Parameter TAG_W, default 4: width of the opaque per-operation tag.
REQ-004 clock  input  1  sole clock; all state SHALL update on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  an operation is presented.
REQ-007 in_ready  output  1  the block accepts the operation this cycle.
REQ-008 operandA, operandB  input  WIDTH each  two's-complement operands.
REQ-009 subtraction  input  1  0 = A+B; 1 = A-B.
REQ-010 in_tag  input  TAG_W  tag returned unchanged with the result.
REQ-011 out_valid  output  1  a result is presented.
REQ-012 out_ready  input  1  the consumer accepts the result this cycle.
REQ-013 result  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-014 out_tag  output  TAG_W  tag of the presented result.
REQ-015 carry_out, overflow, isNotEqual, isLessThan  output  1 each  flags, defined in the Function section.

Function
REQ-016 Acceptance: an operation transfers when in_valid and in_ready are both 1; a result transfers when out_valid and out_ready are both 1.
REQ-017 Advance rule: advance = !out_valid || out_ready; in_ready SHALL equal advance; all stages SHALL shift together only when advance is 1 and SHALL otherwise hold every register.
REQ-018 Bubbles: when advance is 1 and in_valid is 0, stage 0 SHALL load valid=0; bubbles SHALL propagate and SHALL never assert out_valid.
REQ-019 Operand conditioning: B is inverted when subtraction is 1; the stage-0 carry-in SHALL equal subtraction.
REQ-020 Per-stage work: stage k SHALL add slice k (bits k*SLICE .. k*SLICE+SLICE-1), using slice-level carry-lookahead (generate/propagate). It SHALL register the slice sum and the slice carry-out, and forward the carry-out as the carry-in of stage k+1.
REQ-021 Skew: unprocessed operand slices SHALL travel with the operation; finished sum slices SHALL be delayed so that all WIDTH bits of result emerge in the same cycle.
REQ-022 Latency: a result SHALL appear exactly STAGES cycles after acceptance when out_ready is held at 1; throughput SHALL be one operation per cycle.
REQ-023 Ordering: results SHALL leave in acceptance order, each with its own tag and flags; there SHALL be no loss or duplication under any out_ready pattern.
REQ-024 carry_out SHALL be the final slice carry-out (for subtraction, 1 means no unsigned borrow).
REQ-025 overflow SHALL be the signed overflow: the carry into the MSB XOR carry_out.
REQ-026 isNotEqual SHALL be the OR of all result bits.
REQ-027 isLessThan SHALL be result[WIDTH-1] XOR overflow when subtraction is 1, and 0 when subtraction is 0. It is a signed comparison that stays correct under overflow.
REQ-028 Flag timing: the flags SHALL be valid in the same cycle as result. They SHALL be held stable, together with result and out_tag, while out_valid is 1 and out_ready is 0.
REQ-029 Simultaneous events: when the output transfers and a new input is accepted in the same cycle, both SHALL occur with no bubble inserted.
REQ-030 Don't-care outputs: while out_valid is 0, result, out_tag and the flags are don't-care, but SHALL NOT be X after reset.

Reset
REQ-031 While reset is 1, every stage valid bit SHALL clear. All datapath registers SHALL clear to 0. out_valid=0 and in_ready=1 in the cycle after reset is sampled.
REQ-032 An asserted reset SHALL discard all in-flight operations; no partial result SHALL ever be presented afterwards.
REQ-033 in_valid SHALL be ignored in any cycle in which reset is 1.

Verification (WIDTH=32, STAGES=4, out_ready=1 unless stated)
REQ-034 Add 5 + 3, tag 2 -> 4 cycles later: result=0x00000008, out_tag=2, carry_out=0, overflow=0, isNotEqual=1, isLessThan=0.
REQ-035 Add 0x000000FF + 0x00000001 -> result 0x00000100. Add 0xFFFFFFFF + 0x00000001 -> result 0x00000000, carry_out=1, isNotEqual=0. This exercises the slice carry chain.
REQ-036 Subtract 0x7FFFFFFF - 0xFFFFFFFF -> result 0x80000000, overflow=1, isLessThan=0. Subtract 0xFFFFFFFE - 0x00000001 -> isLessThan=1, overflow=0. Subtract 7 - 7 -> result 0, isNotEqual=0, carry_out=1.
REQ-037 Issue 6 back-to-back operations with tags 0..5; hold out_ready=0 for 3 cycles once the first result appears -> in_ready=0 and result stable while stalled. All 6 results then leave in tag order, none lost or duplicated.
REQ-038 Assert reset for 1 cycle with 3 operations in flight -> next cycle out_valid=0 and in_ready=1. None of the 3 results ever appears. A following operation 1 + 1 returns 2 after 4 cycles.

Source files
------------

// File: rtl/adder_pipe.sv
// rtl/adder_pipe.sv - pipelined add/subtract with one carry-lookahead slice per stage
// Operand remainders shift down each stage; finished sum slices accumulate upward.
module adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic             subtraction,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] out_tag,
  output logic             carry_out,
  output logic             overflow,
  output logic             isNotEqual,
  output logic             isLessThan
);

  localparam int SLICE = WIDTH / STAGES;

  logic advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int IN_W   = WIDTH - k * SLICE;
    localparam int DONE_W = (k + 1) * SLICE;

    logic [IN_W-1:0]   a_in, b_in;
    logic              cin, v_in, sub_in;
    logic [TAG_W-1:0]  tag_in;
    logic [SLICE-1:0]  g_w, p_w, s_w;
    logic [SLICE:0]    c_w;
    logic [DONE_W-1:0] sum_d, sum_q;
    logic              valid_q, sub_q, carry_q;
    logic [TAG_W-1:0]  tag_q;

    if (k == 0) begin : g_head
      assign a_in   = operandA;
      assign b_in   = operandB ^ {WIDTH{subtraction}};
      assign cin    = subtraction;
      assign v_in   = in_valid;
      assign sub_in = subtraction;
      assign tag_in = in_tag;
      assign sum_d  = s_w;
    end else begin : g_body
      assign a_in   = g_stage[k-1].g_ops.a_q;
      assign b_in   = g_stage[k-1].g_ops.b_q;
      assign cin    = g_stage[k-1].carry_q;
      assign v_in   = g_stage[k-1].valid_q;
      assign sub_in = g_stage[k-1].sub_q;
      assign tag_in = g_stage[k-1].tag_q;
      assign sum_d  = {s_w, g_stage[k-1].sum_q};
    end

    always_comb begin
      g_w    = a_in[SLICE-1:0] & b_in[SLICE-1:0];
      p_w    = a_in[SLICE-1:0] ^ b_in[SLICE-1:0];
      c_w    = '0;
      c_w[0] = cin;
      for (int i = 0; i < SLICE; i++) begin
        c_w[i+1] = g_w[i] | (p_w[i] & c_w[i]);
      end
      s_w = p_w ^ c_w[SLICE-1:0];
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        valid_q <= 1'b0;
        sub_q   <= 1'b0;
        carry_q <= 1'b0;
        tag_q   <= '0;
        sum_q   <= '0;
      end else if (advance) begin
        valid_q <= v_in;
        sub_q   <= sub_in;
        carry_q <= c_w[SLICE];
        tag_q   <= tag_in;
        sum_q   <= sum_d;
      end
    end

    // Only the slices not yet added travel on to the next stage.
    if (k < STAGES - 1) begin : g_ops
      logic [IN_W-SLICE-1:0] a_q, b_q;
      always_ff @(posedge clock) begin
        if (reset) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_in[IN_W-1:SLICE];
          b_q <= b_in[IN_W-1:SLICE];
        end
      end
    end

    if (k == STAGES - 1) begin : g_tail
      logic cmsb_q;
      always_ff @(posedge clock) begin
        if (reset)        cmsb_q <= 1'b0;
        else if (advance) cmsb_q <= c_w[SLICE-1];
      end
    end
  end

  assign out_valid  = g_stage[STAGES-1].valid_q;
  assign advance    = !out_valid || out_ready;
  assign in_ready   = advance;
  assign result     = g_stage[STAGES-1].sum_q;
  assign out_tag    = g_stage[STAGES-1].tag_q;
  assign carry_out  = g_stage[STAGES-1].carry_q;
  assign overflow   = g_stage[STAGES-1].g_tail.cmsb_q ^ carry_out;
  assign isNotEqual = |result;
  assign isLessThan = g_stage[STAGES-1].sub_q & (result[WIDTH-1] ^ overflow);

endmodule

// File: tb/tb_adder_pipe.sv
// tb/tb_adder_pipe.sv - directed-vector bench for adder_pipe
module tb_adder_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] operandA, operandB;
  logic        subtraction;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  out_tag;
  logic        carry_out, overflow, isNotEqual, isLessThan;

  int vectors = 0;
  int miscompares = 0;

  adder_pipe #(.WIDTH(32), .STAGES(4), .TAG_W(4)) dut (
    .clock(clk), .reset(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .operandA(operandA), .operandB(operandB),
    .subtraction(subtraction), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_tag(out_tag),
    .carry_out(carry_out), .overflow(overflow),
    .isNotEqual(isNotEqual), .isLessThan(isLessThan)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1);
  end

  task automatic chk32(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic chk1(input string name, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", name, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [3:0] tag, input logic [31:0] er,
                         input logic ec, input logic eo, input logic ene, input logic elt);
    in_valid = 1'b1; operandA = a; operandB = b; subtraction = sub; in_tag = tag;
    out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    chk1({name, "_early"}, out_valid, 1'b0);
    tick;
    chk1({name, "_valid"}, out_valid, 1'b1);
    chk32({name, "_result"}, result, er);
    chk32({name, "_tag"}, 32'(out_tag), 32'(tag));
    chk1({name, "_carry"}, carry_out, ec);
    chk1({name, "_ovf"}, overflow, eo);
    chk1({name, "_ne"}, isNotEqual, ene);
    chk1({name, "_lt"}, isLessThan, elt);
  endtask

  function automatic logic [31:0] b2b_exp(input int i);
    return 32'h1111_1111 * 32'(i + 1) + 32'h0F0F_0F0F;
  endfunction

  initial begin
    int issued, received, stall, seen;
    logic first_seen;

    rst = 1'b1; in_valid = 1'b1; operandA = 32'h1234_5678; operandB = 32'h1;
    subtraction = 1'b0; in_tag = 4'hA; out_ready = 1'b1;
    tick;
    tick;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk32("rst_result", result, 32'h0);
    chk32("rst_tag", 32'(out_tag), 32'h0);
    rst = 1'b0; in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (out_valid) seen++;
    end
    chk32("rst_ignored_valid", 32'(seen), 32'd0);

    run_one("add5_3", 32'd5, 32'd3, 1'b0, 4'd2, 32'h0000_0008, 1'b0, 1'b0, 1'b1, 1'b0);
    run_one("addff", 32'h0000_00FF, 32'h1, 1'b0, 4'd1, 32'h0000_0100, 1'b0, 1'b0, 1'b1, 1'b0);
    run_one("addwrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 4'd3, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_one("addovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 4'd4, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
    run_one("addneg", 32'h8000_0000, 32'h1, 1'b0, 4'd5, 32'h8000_0001, 1'b0, 1'b0, 1'b1, 1'b0);
    run_one("subovf", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'd6, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
    run_one("subneg", 32'hFFFF_FFFE, 32'h1, 1'b1, 4'd7, 32'hFFFF_FFFD, 1'b1, 1'b0, 1'b1, 1'b1);
    run_one("subeq", 32'd7, 32'd7, 1'b1, 4'd8, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_one("sub3_5", 32'd3, 32'd5, 1'b1, 4'd9, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b1);
    tick;

    issued = 0; received = 0; stall = 0; first_seen = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (out_valid && !first_seen) begin
        first_seen = 1'b1;
        stall = 3;
      end
      out_ready   = (stall == 0);
      in_valid    = (issued < 6);
      operandA    = 32'h1111_1111 * 32'(issued + 1);
      operandB    = 32'h0F0F_0F0F;
      subtraction = 1'b0;
      in_tag      = 4'(issued);
      #1;
      if (stall > 0) begin
        chk1("stall_in_ready", in_ready, 1'b0);
        chk1("stall_valid", out_valid, 1'b1);
        chk32("stall_result", result, b2b_exp(received));
        chk32("stall_tag", 32'(out_tag), 32'(received));
        stall--;
      end else if (out_valid) begin
        chk32("b2b_tag", 32'(out_tag), 32'(received));
        chk32("b2b_result", result, b2b_exp(received));
        received++;
      end
      if (in_valid && in_ready) issued++;
      tick;
    end
    chk32("b2b_received", 32'(received), 32'd6);
    chk32("b2b_issued", 32'(issued), 32'd6);
    in_valid = 1'b0; out_ready = 1'b1;

    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; operandA = 32'h100 + 32'(i); operandB = 32'h1;
      subtraction = 1'b0; in_tag = 4'(7 + i);
      tick;
    end
    rst = 1'b1; in_valid = 1'b1; operandA = 32'h55; in_tag = 4'hF;
    tick;
    rst = 1'b0; in_valid = 1'b0;
    chk1("flush_out_valid", out_valid, 1'b0);
    chk1("flush_in_ready", in_ready, 1'b1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (out_valid) seen++;
    end
    chk32("flush_none_seen", 32'(seen), 32'd0);
    run_one("post_rst", 32'd1, 32'd1, 1'b0, 4'd3, 32'd2, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
